// File: rtl/botsw_gate_ctrl.sv
// botsw_gate_ctrl: break-before-make gate sequencer for the low-side power NMOS.
// Turns pwm_in into a gate command with a dead-time delay, a minimum on-time
// and a latched fault. Top-switch gate feedback blocks shoot-through.
// Optional feature: define BOTSW_DIODE_EMU_EN to add the zcd input (diode
// emulation). With the macro undefined the switch follows pwm_in
// (synchronous rectification).
module botsw_gate_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  input  logic             top_gate_fb,
  input  logic [CNT_W-1:0] dt_cyc,
  input  logic [CNT_W-1:0] min_on_cyc,
  input  logic             oc_flt,
  input  logic             flt_clr,
`ifdef BOTSW_DIODE_EMU_EN
  input  logic             zcd,
`endif
  output logic             gate,
  output logic             flt,
  output logic [1:0]       flt_code,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    S_OFF   = 2'b00,
    S_DEAD  = 2'b01,
    S_ON    = 2'b10,
    S_FAULT = 2'b11
  } state_t;

  localparam logic [1:0] CODE_NONE  = 2'b00;
  localparam logic [1:0] CODE_OC    = 2'b01;
  localparam logic [1:0] CODE_SHOOT = 2'b10;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       code_d;
  logic             armed_q, armed_d;

  // Next-state logic: overcurrent first, then shoot-through, then normal sequencing.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = flt_code;
    armed_d = armed_q;

    unique case (state_q)
      S_OFF: begin
        if (oc_flt) begin
          state_d = S_FAULT;
          code_d  = CODE_OC;
          cnt_d   = '0;
`ifdef BOTSW_DIODE_EMU_EN
        end else if (pwm_in && !top_gate_fb && armed_q) begin
`else
        end else if (pwm_in && !top_gate_fb) begin
`endif
          state_d = S_DEAD;
          cnt_d   = dt_cyc;
        end
      end

      S_DEAD: begin
        if (oc_flt) begin
          state_d = S_FAULT;
          code_d  = CODE_OC;
          cnt_d   = '0;
        end else if (!pwm_in || top_gate_fb) begin
          // Request withdrawn or top switch still on: abort quietly.
          state_d = S_OFF;
          cnt_d   = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = S_ON;
          cnt_d   = min_on_cyc;
        end
      end

      S_ON: begin
        if (oc_flt) begin
          state_d = S_FAULT;
          code_d  = CODE_OC;
          cnt_d   = '0;
        end else if (top_gate_fb) begin
          // Both switches on: fault immediately, min-on is not honoured.
          state_d = S_FAULT;
          code_d  = CODE_SHOOT;
          cnt_d   = '0;
        end else if (cnt_q == '0 && !pwm_in) begin
          state_d = S_OFF;
`ifdef BOTSW_DIODE_EMU_EN
        end else if (cnt_q == '0 && zcd) begin
          // Inductor current reached zero: release and wait for a fresh pwm cycle.
          state_d = S_OFF;
          armed_d = 1'b0;
`endif
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_FAULT: begin
        if (flt_clr && !oc_flt && !pwm_in) begin
          state_d = S_OFF;
          code_d  = CODE_NONE;
        end
      end

      default: begin
        state_d = S_OFF;
        cnt_d   = '0;
      end
    endcase

`ifdef BOTSW_DIODE_EMU_EN
    // Any low pwm sample re-arms turn-on after a zero-current release.
    if (!pwm_in) armed_d = 1'b1;
`endif
  end

  // State, counter and registered outputs; reset forces the gate off at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_OFF;
      cnt_q    <= '0;
      armed_q  <= 1'b1;
      gate     <= 1'b0;
      flt      <= 1'b0;
      flt_code <= CODE_NONE;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, regardless of statement order.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      armed_q  <= armed_d;
      gate     <= (state_d == S_ON);
      flt      <= (state_d == S_FAULT);
      flt_code <= code_d;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_botsw_gate_ctrl.sv
// Directed bench for botsw_gate_ctrl; expected values are hand-derived.
module tb_botsw_gate_ctrl;

  localparam int CNT_W = 8;
  localparam logic [1:0] OFF = 2'b00, DEAD = 2'b01, ON = 2'b10, FAULT = 2'b11;

  logic             clk = 1'b0;
  logic             rst;
  logic             pwm_in, top_gate_fb, oc_flt, flt_clr;
  logic [CNT_W-1:0] dt_cyc, min_on_cyc;
`ifdef BOTSW_DIODE_EMU_EN
  logic             zcd;
`endif
  logic             gate, flt;
  logic [1:0]       flt_code, state;

  int checks = 0;
  int errors = 0;

  botsw_gate_ctrl #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .pwm_in      (pwm_in),
    .top_gate_fb (top_gate_fb),
    .dt_cyc      (dt_cyc),
    .min_on_cyc  (min_on_cyc),
    .oc_flt      (oc_flt),
    .flt_clr     (flt_clr),
`ifdef BOTSW_DIODE_EMU_EN
    .zcd         (zcd),
`endif
    .gate        (gate),
    .flt         (flt),
    .flt_code    (flt_code),
    .state       (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit before sampling/driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [1:0] st, input logic g,
                            input logic f, input logic [1:0] code);
    check({tag, ".state"}, 32'(state), 32'(st));
    check({tag, ".gate"},  32'(gate),  32'(g));
    check({tag, ".flt"},   32'(flt),   32'(f));
    check({tag, ".code"},  32'(flt_code), 32'(code));
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; pwm_in = 1'b0; top_gate_fb = 1'b0; oc_flt = 1'b0; flt_clr = 1'b0;
    dt_cyc = 8'd4; min_on_cyc = 8'd0;
`ifdef BOTSW_DIODE_EMU_EN
    zcd = 1'b0;
`endif
    #1;
    expect_out("reset", OFF, 1'b0, 1'b0, 2'b00);
    tick(); tick();
    rst = 1'b0;
    tick();
    expect_out("idle", OFF, 1'b0, 1'b0, 2'b00);

    // 1: dead time 4 -> DEAD after edges k..k+4, ON after k+5; min-on 0.
    pwm_in = 1'b1;
    for (int i = 0; i <= 4; i++) begin
      tick();
      check($sformatf("t1.dead%0d.state", i), 32'(state), 32'(DEAD));
      check($sformatf("t1.dead%0d.gate", i),  32'(gate),  32'(0));
    end
    tick();
    expect_out("t1.on", ON, 1'b1, 1'b0, 2'b00);
    pwm_in = 1'b0;
    tick();
    expect_out("t1.off", OFF, 1'b0, 1'b0, 2'b00);

    // 2: min-on 6, dead 0. ON entered at edge e with cnt=6; pwm held through
    // e+1, low after. cnt reaches 0 at e+6, so gate drops at e+7.
    dt_cyc = 8'd0; min_on_cyc = 8'd6;
    pwm_in = 1'b1;
    tick();
    check("t2.dead", 32'(state), 32'(DEAD));
    tick();
    check("t2.on.gate", 32'(gate), 32'(1));
    tick();
    pwm_in = 1'b0;
    for (int i = 2; i <= 6; i++) begin
      tick();
      check($sformatf("t2.minon%0d.gate", i), 32'(gate), 32'(1));
    end
    tick();
    expect_out("t2.off", OFF, 1'b0, 1'b0, 2'b00);

    // 3a: top feedback during DEAD aborts to OFF without fault and blocks entry.
    dt_cyc = 8'd3; min_on_cyc = 8'd10;
    pwm_in = 1'b1;
    tick(); tick();
    check("t3a.dead", 32'(state), 32'(DEAD));
    top_gate_fb = 1'b1;
    tick();
    expect_out("t3a.abort", OFF, 1'b0, 1'b0, 2'b00);
    tick();
    check("t3a.blocked", 32'(state), 32'(OFF));
    top_gate_fb = 1'b0;

    // 3b: top feedback during ON -> FAULT code 10, overriding min-on.
    dt_cyc = 8'd0;
    tick();
    check("t3b.dead", 32'(state), 32'(DEAD));
    tick();
    check("t3b.on.gate", 32'(gate), 32'(1));
    top_gate_fb = 1'b1;
    tick();
    expect_out("t3b.shoot", FAULT, 1'b0, 1'b1, 2'b10);
    top_gate_fb = 1'b0; pwm_in = 1'b0; flt_clr = 1'b1;
    tick();
    expect_out("t3b.clr", OFF, 1'b0, 1'b0, 2'b00);
    flt_clr = 1'b0;

    // 4: OC and shoot-through together while ON -> OC wins (01).
    pwm_in = 1'b1;
    tick(); tick();
    check("t4.on.gate", 32'(gate), 32'(1));
    oc_flt = 1'b1; top_gate_fb = 1'b1;
    tick();
    expect_out("t4.oc", FAULT, 1'b0, 1'b1, 2'b01);
    oc_flt = 1'b0; top_gate_fb = 1'b0; flt_clr = 1'b1;
    tick();
    expect_out("t4.clr_pwm_hi", FAULT, 1'b0, 1'b1, 2'b01);
    pwm_in = 1'b0; oc_flt = 1'b1;
    tick();
    expect_out("t4.clr_oc_hi", FAULT, 1'b0, 1'b1, 2'b01);
    oc_flt = 1'b0;
    tick();
    expect_out("t4.clr", OFF, 1'b0, 1'b0, 2'b00);
    flt_clr = 1'b0;
    // Overcurrent while idle also latches.
    oc_flt = 1'b1;
    tick();
    expect_out("t4.oc_off", FAULT, 1'b0, 1'b1, 2'b01);
    oc_flt = 1'b0;
    tick();
    check("t4.hold", 32'(flt_code), 32'(2'b01));
    flt_clr = 1'b1;
    tick();
    check("t4.clr2", 32'(state), 32'(OFF));
    flt_clr = 1'b0;

    // 5: reset mid-ON with min-on 200 drops gate asynchronously; re-entry needs DT.
    dt_cyc = 8'd2; min_on_cyc = 8'd200;
    pwm_in = 1'b1;
    tick(); tick(); tick();
    check("t5.dead", 32'(state), 32'(DEAD));
    tick();
    check("t5.on.gate", 32'(gate), 32'(1));
    tick(); tick();
    check("t5.on_hold", 32'(gate), 32'(1));
    #2 rst = 1'b1;
    #1;
    expect_out("t5.async", OFF, 1'b0, 1'b0, 2'b00);
    tick();
    rst = 1'b0;
    for (int i = 0; i <= 2; i++) begin
      tick();
      check($sformatf("t5.redead%0d.state", i), 32'(state), 32'(DEAD));
      check($sformatf("t5.redead%0d.gate", i),  32'(gate),  32'(0));
    end
    tick();
    check("t5.reon", 32'(gate), 32'(1));
    pwm_in = 1'b0;

`ifdef BOTSW_DIODE_EMU_EN
    // 6: zcd releases the switch; no re-entry until pwm cycles 0->1.
    rst = 1'b1; #1; rst = 1'b0;
    dt_cyc = 8'd0; min_on_cyc = 8'd0;
    tick();
    pwm_in = 1'b1;
    tick(); tick();
    check("t6.on", 32'(gate), 32'(1));
    zcd = 1'b1;
    tick();
    expect_out("t6.zcd_off", OFF, 1'b0, 1'b0, 2'b00);
    zcd = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("t6.disarmed%0d", i), 32'(state), 32'(OFF));
    end
    pwm_in = 1'b0;
    tick();
    pwm_in = 1'b1;
    tick();
    check("t6.rearm", 32'(state), 32'(DEAD));
    tick();
    check("t6.reon", 32'(gate), 32'(1));
    pwm_in = 1'b0;
`endif

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
